// File: rtl/blk_mem_pkg.sv
// rtl/blk_mem_pkg.sv - shared constants for block RAM clients
package blk_mem_pkg;

  // Reader FSM encoding, kept as plain constants so older clients can reuse it
  typedef logic [1:0] rd_state_t;
  localparam rd_state_t ST_IDLE  = 2'd0;
  localparam rd_state_t ST_READ  = 2'd1;
  localparam rd_state_t ST_FLUSH = 2'd2;

  // Entries in the read-data skid buffer
  localparam int SKID_DEPTH = 2;

  // Clocks from address to data on the RAM read port
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/blk_mem_reader_skid.sv
// rtl/blk_mem_reader_skid.sv - two-entry skid FIFO for returned RAM words
module blk_mem_reader_skid
  import blk_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  // Next-state for storage, pointers and occupancy; pop of an empty FIFO is ignored
  always_comb begin
    do_pop   = i_pop && (count_q != 2'd0);
    do_push  = i_push && ((count_q != 2'(SKID_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // Register update; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/blk_mem_reader.sv
// rtl/blk_mem_reader.sv - streams a wrapping RAM address range out as valid/ready beats
module blk_mem_reader
  import blk_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]    i_mem_data,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic                     o_last,
  input  logic                     i_ready
);

  localparam int CW = ADDRESS_WIDTH + 1;

  rd_state_t              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]          issue_rem_q, issue_rem_d;
  logic [CW-1:0]          beat_rem_q, beat_rem_d;
  logic                   inflight_q, inflight_d;

  logic [1:0]             fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic                   handshake;
  logic                   issue;
  logic [2:0]             credit_after;

  // The word returning this cycle always has a slot: issue never lets
  // buffered + in-flight exceed the skid depth.
  blk_mem_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (inflight_q),
    .i_push_data (i_mem_data),
    .i_pop       (handshake),
    .o_head      (fifo_head),
    .o_count     (fifo_count)
  );

  // Issue a read when words remain and the slot freed by this cycle's handshake keeps credit under the skid depth
  always_comb begin
    handshake    = (fifo_count != 2'd0) && i_ready;
    credit_after = 3'(fifo_count) + 3'(inflight_q) - 3'(handshake);
    issue        = (state_q == ST_READ) && (issue_rem_q != '0) &&
                   (credit_after < 3'(SKID_DEPTH));
  end

  // FSM, address pointer, issue and beat counters
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    issue_rem_d = issue_rem_q;
    beat_rem_d  = beat_rem_q;
    inflight_d  = issue;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          ptr_d       = i_base_addr;
          issue_rem_d = i_count;
          beat_rem_d  = i_count;
          state_d     = (i_count == '0) ? ST_FLUSH : ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          ptr_d       = ptr_q + ADDRESS_WIDTH'(1);
          issue_rem_d = issue_rem_q - CW'(1);
        end
        if (handshake) begin
          beat_rem_d = beat_rem_q - CW'(1);
          if (beat_rem_q == CW'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset drops any read still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      issue_rem_q <= issue_rem_d;
      beat_rem_q  <= beat_rem_d;
      inflight_q  <= inflight_d;
    end
  end

  assign o_mem_addr = ptr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_FLUSH);
  assign o_valid    = (fifo_count != 2'd0);
  assign o_data     = fifo_head;
  assign o_last     = o_valid && (beat_rem_q == CW'(1));

endmodule
